// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART register slave: register indices, reset values,
// bus FSM states and interrupt event bit positions.
package apb_uart_pkg;

  localparam logic [3:0] REG_MDR = 4'd0;
  localparam logic [3:0] REG_DLL = 4'd1;
  localparam logic [3:0] REG_DLH = 4'd2;
  localparam logic [3:0] REG_LCR = 4'd3;
  localparam logic [3:0] REG_IER = 4'd4;
  localparam logic [3:0] REG_FSR = 4'd5;
  localparam logic [3:0] REG_TBR = 4'd6;
  localparam logic [3:0] REG_RBR = 4'd7;
  localparam logic [3:0] REG_ISR = 4'd8;

  localparam logic [7:0] MDR_RST = 8'h00;
  localparam logic [7:0] DLL_RST = 8'h00;
  localparam logic [7:0] DLH_RST = 8'h00;
  localparam logic [7:0] LCR_RST = 8'h03;
  localparam logic [7:0] IER_RST = 8'h00;
  localparam logic [7:0] TBR_RST = 8'h00;
  localparam logic [7:0] ISR_RST = 8'h00;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} apb_state_e;

  localparam int ISR_TX_EMPTY   = 0;
  localparam int ISR_RX_AVAIL   = 1;
  localparam int ISR_LINE_ERR   = 2;
  localparam int ISR_RX_TIMEOUT = 3;

  // Baud/line configuration registers are the privileged subset.
  function automatic logic is_cfg_reg(input logic [3:0] idx);
    return idx <= REG_LCR;
  endfunction

endpackage

// File: rtl/apb_uart_isr.sv
// Sticky interrupt status register (set by event pulses, write-1-to-clear) with a
// registered, IER-masked interrupt output. Set wins over a simultaneous clear.
module apb_uart_isr
  import apb_uart_pkg::*;
#(
  parameter int NUM_EVT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] evt,
  input  logic [NUM_EVT-1:0] clr,
  input  logic [NUM_EVT-1:0] ier,
  output logic [NUM_EVT-1:0] isr,
  output logic               irq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      isr <= NUM_EVT'(ISR_RST);
      irq <= 1'b0;
    end else begin
      isr <= (isr & ~clr) | evt;
      irq <= |(isr & ier);
    end
  end

endmodule

// File: rtl/apb_uart_csr.sv
// APB4 register slave for the UART: wait states, PSTRB[0] write gating, PSLVERR on bad
// accesses, W1C interrupt status. Optional privilege check enabled by APB_UART_PPROT_EN.
module apb_uart_csr
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int NUM_EVT     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
`ifdef APB_UART_PPROT_EN
  input  logic [2:0]          PPROT,
`endif
  output logic                PREADY,
  output logic                PSLVERR,
  output logic [DATA_W-1:0]   PRDATA,
  output logic [7:0]          MDR,
  output logic [7:0]          DLL,
  output logic [7:0]          DLH,
  output logic [7:0]          LCR,
  output logic [7:0]          IER,
  output logic [7:0]          TBR,
  output logic                tx_flag,
  output logic                rx_flag,
  input  logic [7:0]          FSR,
  input  logic [7:0]          RBR,
  input  logic [NUM_EVT-1:0]  evt,
  output logic                irq
);

  apb_state_e         state;
  logic [3:0]         wait_cnt;
  logic [3:0]         idx;
  logic               addr_err, wr_err, priv_err, acc_err;
  logic               enter_done, done_acc, commit;
  logic [7:0]         rd_byte;
  logic [NUM_EVT-1:0] isr, isr_clr;
  logic               unused_bits;

  assign idx      = PADDR[3:0];
  assign addr_err = (idx > REG_ISR) || ((PADDR >> 4) != '0);
  assign wr_err   = PWRITE && (idx == REG_FSR || idx == REG_RBR);
`ifdef APB_UART_PPROT_EN
  assign priv_err    = PWRITE && is_cfg_reg(idx) && !PPROT[0];
  assign unused_bits = ^{PSTRB, PWDATA, PPROT};
`else
  assign priv_err    = 1'b0;
  assign unused_bits = ^{PSTRB, PWDATA};
`endif
  assign acc_err = addr_err | wr_err | priv_err;

  always_comb begin
    rd_byte = '0;
    case (idx)
      REG_MDR: rd_byte = MDR;
      REG_DLL: rd_byte = DLL;
      REG_DLH: rd_byte = DLH;
      REG_LCR: rd_byte = LCR;
      REG_IER: rd_byte = IER;
      REG_FSR: rd_byte = FSR;
      REG_RBR: rd_byte = RBR;
      REG_ISR: rd_byte = 8'(isr);
      default: rd_byte = '0;
    endcase
  end

  assign enter_done = (state == IDLE && PSEL && !PENABLE && WAIT_CYCLES == 0) ||
                      (state == WAIT && PSEL && wait_cnt == 4'd0);
  assign done_acc   = (state == DONE) && PSEL && PENABLE;
  // Writes land on the edge leaving DONE, reusing the error decision the master saw.
  assign commit     = done_acc && PWRITE && PSTRB[0] && !PSLVERR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
    end else begin
      case (state)
        IDLE: if (PSEL && !PENABLE) begin
          if (WAIT_CYCLES == 0) begin
            state <= DONE;
          end else begin
            state    <= WAIT;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (!PSEL)                 state    <= IDLE;
          else if (wait_cnt == 4'd0) state    <= DONE;
          else                       wait_cnt <= wait_cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      PREADY <= enter_done;
      if (enter_done) begin
        PSLVERR <= acc_err;
        PRDATA  <= (acc_err || PWRITE) ? '0 : DATA_W'(rd_byte);
      end else if (state == DONE) begin
        PSLVERR <= 1'b0;
        PRDATA  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MDR     <= MDR_RST;
      DLL     <= DLL_RST;
      DLH     <= DLH_RST;
      LCR     <= LCR_RST;
      IER     <= IER_RST;
      TBR     <= TBR_RST;
      tx_flag <= 1'b0;
      rx_flag <= 1'b0;
    end else begin
      tx_flag <= commit && idx == REG_TBR;
      rx_flag <= done_acc && !PWRITE && !PSLVERR && idx == REG_RBR;
      if (commit) begin
        case (idx)
          REG_MDR: MDR <= PWDATA[7:0];
          REG_DLL: DLL <= PWDATA[7:0];
          REG_DLH: DLH <= PWDATA[7:0];
          REG_LCR: LCR <= PWDATA[7:0];
          REG_IER: IER <= PWDATA[7:0];
          REG_TBR: TBR <= PWDATA[7:0];
          default: ;
        endcase
      end
    end
  end

  assign isr_clr = (commit && idx == REG_ISR) ? PWDATA[NUM_EVT-1:0] : '0;

  apb_uart_isr #(.NUM_EVT(NUM_EVT)) u_isr (
    .clk (clk),
    .rst (rst),
    .evt (evt),
    .clr (isr_clr),
    .ier (IER[NUM_EVT-1:0]),
    .isr (isr),
    .irq (irq)
  );

endmodule
